// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Imported by the arbiter, its picker and the memory bus interface.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  localparam logic GR_I = 1'b0;
  localparam logic GR_D = 1'b1;

  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory bus: arbiter is master, memory model is slave.
// Request side is registered in the master; ack is a 1-cycle pulse.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              xo_req;
  logic              xo_write;
  logic [1:0]        xo_size;
  logic [ADDR_W-1:0] xo_addr;
  logic [DATA_W-1:0] xo_wdata;
  logic [DATA_W-1:0] xi_rdata;
  logic              xi_ack;

  modport master (
    output xo_req, xo_write, xo_size,
    output xo_addr, xo_wdata,
    input  xi_rdata, xi_ack
  );

  modport slave (
    input  xo_req, xo_write, xo_size,
    input  xo_addr, xo_wdata,
    output xi_rdata, xi_ack
  );
endinterface

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Two-requester alternating picker with a last-grant flop.
// Ties go to the side that did not win last time.
module rr_grant2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_i_i,
  input  logic req_d_i,
  output logic vld_o,
  output logic gnt_o
);
  logic last_q;

  assign vld_o = req_i_i | req_d_i;

  always_comb begin
    gnt_o = GR_I;
    unique case (1'b1)
      req_i_i & req_d_i:  gnt_o = ~last_q;
      req_d_i & ~req_i_i: gnt_o = GR_D;
      default:            gnt_o = GR_I;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GR_I;
    end else if (en_i && vld_o) begin
      last_q <= gnt_o;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and the MEM stage.
// Registered bus outputs; done pulses the cycle after the ack edge.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              Fi_req,
  input  logic [ADDR_W-1:0] Fi_addr,
  input  logic              Fi_flush,
  input  logic              Mi_memReq,
  input  logic              Mi_memWrite,
  input  logic [1:0]        Mi_memSize,
  input  logic [ADDR_W-1:0] Mi_addr,
  input  logic [DATA_W-1:0] Mi_wdata,
  output logic [DATA_W-1:0] Fo_rdata,
  output logic              Fo_done,
  output logic              Fo_stall,
  output logic [DATA_W-1:0] Mo_rdata,
  output logic              Mo_done,
  output logic              Mo_stall,
  mem_port_arbiter_if.master bus
);
  state_e            state_q;
  logic              drop_q;
  logic              req_q;
  logic              wr_q;
  logic [1:0]        sz_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] frd_q;
  logic [DATA_W-1:0] mrd_q;
  logic              fdone_q;
  logic              mdone_q;

  logic idle;
  logic f_req;
  logic m_req;
  logic gnt_vld;
  logic gnt;

  assign idle = (state_q == IDLE);
  // A requester still holds req during its done cycle; mask it then.
  assign f_req = Fi_req & ~Fi_flush & ~fdone_q;
  assign m_req = Mi_memReq & ~mdone_q;

  rr_grant2 u_rr (
    .clk     (clk),
    .rst_n   (reset_x),
    .en_i    (idle),
    .req_i_i (f_req),
    .req_d_i (m_req),
    .vld_o   (gnt_vld),
    .gnt_o   (gnt)
  );

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      sz_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      frd_q   <= '0;
      mrd_q   <= '0;
      fdone_q <= 1'b0;
      mdone_q <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      mdone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            req_q <= 1'b1;
            if (gnt == GR_D) begin
              state_q <= DBUSY;
              wr_q    <= Mi_memWrite;
              sz_q    <= Mi_memSize;
              addr_q  <= Mi_addr;
              wdata_q <= Mi_wdata;
            end else begin
              state_q <= IBUSY;
              wr_q    <= 1'b0;
              sz_q    <= MS_WORD;
              addr_q  <= Fi_addr;
              wdata_q <= '0;
            end
          end
        end
        IBUSY: begin
          if (bus.xi_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            frd_q   <= bus.xi_rdata;
            fdone_q <= ~(drop_q | Fi_flush);
            drop_q  <= 1'b0;
          end else if (Fi_flush) begin
            drop_q <= 1'b1;
          end
        end
        DBUSY: begin
          if (bus.xi_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            mdone_q <= 1'b1;
            if (!wr_q) mrd_q <= bus.xi_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.xo_req   = req_q;
  assign bus.xo_write = wr_q;
  assign bus.xo_size  = sz_q;
  assign bus.xo_addr  = addr_q;
  assign bus.xo_wdata = wdata_q;

  assign Fo_rdata = frd_q;
  assign Fo_done  = fdone_q;
  assign Mo_rdata = mrd_q;
  assign Mo_done  = mdone_q;
  assign Fo_stall = Fi_req & ~fdone_q;
  assign Mo_stall = Mi_memReq & ~mdone_q;
endmodule
